// File: rtl/p2_sprite_render.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : p2_sprite_render
// Description : Player-2 sprite renderer. Runs the stay/move/attack animation
//               sequencer and turns VGA pixel coordinates into sprite ROM
//               addresses. It consumes the returned row bitmap and produces a
//               3-cycle pipelined per-pixel "green on" strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module p2_sprite_render #(
  parameter int SCALE_SHIFT = 2,
  parameter int FRAME_DIV   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        act_valid,
  input  logic [2:0]  act_req,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        pix_on,
  output logic        busy,
  output logic [2:0]  act_cur,
  output logic [1:0]  frame_cur
);

  typedef enum logic [1:0] {
    ST_STAY   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_ATTACK = 2'd2
  } state_t;

  // Sprite box edge in screen pixels (16 texels, each magnified).
  localparam int         C_BOX      = 16 << SCALE_SHIFT;
  localparam logic [3:0] C_DIV_LAST = 4'(FRAME_DIV - 1);

  state_t      state_q, state_d;
  logic [2:0]  act_q, act_d;
  logic [1:0]  frame_q, frame_d;
  logic [3:0]  div_q, div_d;
  logic [2:0]  shadow_act_q, shadow_act_d;
  logic [1:0]  shadow_frame_q, shadow_frame_d;
  logic [9:0]  rom_addr_q, rom_addr_d;
  logic        in_box1_q, in_box1_d;
  logic [3:0]  col1_q, col1_d;
  logic        in_box2_q, in_box2_d;
  logic [3:0]  col2_q, col2_d;
  logic        pix_on_q, pix_on_d;

  logic        req_ok;
  logic        div_wrap;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_box;
  logic [3:0]  row;
  logic [3:0]  col;

  // Sequencer next state: action switches take priority over frame advance.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    frame_d  = frame_q;
    div_d    = div_q;
    req_ok   = act_valid && (act_req <= 3'd4);
    div_wrap = frame_tick && (div_q == C_DIV_LAST);
    case (state_q)
      ST_STAY, ST_MOVE: begin
        if (req_ok && (act_req != act_q)) begin
          act_d   = act_req;
          frame_d = 2'd0;
          div_d   = 4'd0;
          if (act_req == 3'd0)
            state_d = ST_STAY;
          else if (act_req <= 3'd2)
            state_d = ST_MOVE;
          else
            state_d = ST_ATTACK;
        end else if ((state_q == ST_MOVE) && !act_valid) begin
          state_d = ST_STAY;
          act_d   = 3'd0;
          frame_d = 2'd0;
          div_d   = 4'd0;
        end else if (frame_tick) begin
          if (div_wrap) begin
            div_d   = 4'd0;
            frame_d = frame_q + 2'd1;  // 3 wraps to 0 for looping poses
          end else begin
            div_d   = div_q + 4'd1;
          end
        end
      end
      ST_ATTACK: begin
        if (frame_tick) begin
          if (div_wrap) begin
            div_d = 4'd0;
            if (frame_q == 2'd3) begin
              state_d = ST_STAY;
              act_d   = 3'd0;
              frame_d = 2'd0;
            end else begin
              frame_d = frame_q + 2'd1;
            end
          end else begin
            div_d = div_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_STAY;
        act_d   = 3'd0;
        frame_d = 2'd0;
        div_d   = 4'd0;
      end
    endcase
  end

  // Render pipeline: shadow pose capture, box test / address, bitmap lookup.
  always_comb begin
    shadow_act_d   = frame_tick ? act_q   : shadow_act_q;
    shadow_frame_d = frame_tick ? frame_q : shadow_frame_q;
    dx             = {1'b0, pix_x} - {1'b0, pos_x};
    dy             = {1'b0, pix_y} - {1'b0, pos_y};
    in_box         = !dx[10] && !dy[10] && (dx < 11'(C_BOX)) && (dy < 11'(C_BOX));
    row            = dy[SCALE_SHIFT +: 4];
    col            = dx[SCALE_SHIFT +: 4];
    rom_addr_d     = in_box ? {row, shadow_act_q, 1'b0, shadow_frame_q} : 10'd0;
    in_box1_d      = in_box;
    col1_d         = col;
    in_box2_d      = in_box1_q;
    col2_d         = col1_q;
    // Bit 0 is a figure pixel; column 0 sits in the MSB.
    pix_on_d       = in_box2_q & ~rom_data[4'd15 - col2_q];
  end

  // State and pipeline registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_STAY;
      act_q          <= 3'd0;
      frame_q        <= 2'd0;
      div_q          <= 4'd0;
      shadow_act_q   <= 3'd0;
      shadow_frame_q <= 2'd0;
      rom_addr_q     <= 10'd0;
      in_box1_q      <= 1'b0;
      col1_q         <= 4'd0;
      in_box2_q      <= 1'b0;
      col2_q         <= 4'd0;
      pix_on_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      act_q          <= act_d;
      frame_q        <= frame_d;
      div_q          <= div_d;
      shadow_act_q   <= shadow_act_d;
      shadow_frame_q <= shadow_frame_d;
      rom_addr_q     <= rom_addr_d;
      in_box1_q      <= in_box1_d;
      col1_q         <= col1_d;
      in_box2_q      <= in_box2_d;
      col2_q         <= col2_d;
      pix_on_q       <= pix_on_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix_on    = pix_on_q;
  assign busy      = (state_q == ST_ATTACK);
  assign act_cur   = act_q;
  assign frame_cur = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_p2_sprite_render.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_p2_sprite_render
// Description : Self-checking bench for p2_sprite_render with a ROM model and
//               an arithmetic reference for pose timing and pixel lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p2_sprite_render;

  localparam int SS  = 2;
  localparam int FD  = 6;
  localparam int BOX = 16 << SS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        act_valid = 1'b0;
  logic [2:0]  act_req = 3'd0;
  logic [9:0]  pos_x = 10'd100;
  logic [9:0]  pos_y = 10'd200;
  logic [9:0]  pix_x = 10'd0;
  logic [9:0]  pix_y = 10'd0;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data = 16'd0;
  logic        pix_on;
  logic        busy;
  logic [2:0]  act_cur;
  logic [1:0]  frame_cur;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] rom_mem [1024];
  int          m_sa = 0;
  int          m_sf = 0;
  bit          exp_q [$];
  logic [9:0]  addr_snap;

  p2_sprite_render #(.SCALE_SHIFT(SS), .FRAME_DIV(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .act_valid  (act_valid),
    .act_req    (act_req),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_on     (pix_on),
    .busy       (busy),
    .act_cur    (act_cur),
    .frame_cur  (frame_cur)
  );

  always #5 clk = ~clk;

  // Registered-read sprite ROM.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ftick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic fticks(int n);
    repeat (n) ftick();
  endtask

  // Expected ROM address for a pixel, or -1 when outside the sprite box.
  function automatic int model_addr(int px, int py);
    int dx;
    int dy;
    dx = px - int'(pos_x);
    dy = py - int'(pos_y);
    if (dx < 0 || dy < 0 || dx >= BOX || dy >= BOX) return -1;
    return ((dy >> SS) * 64) + (m_sa * 8) + m_sf;
  endfunction

  // Present one pixel; check its address next cycle and pix_on 3 cycles on.
  task automatic present(int px, int py);
    int          a;
    int          col;
    bit          e;
    logic [15:0] w;
    pix_x = 10'(px);
    pix_y = 10'(py);
    a = model_addr(px, py);
    if (a < 0) begin
      e = 1'b0;
    end else begin
      col = (px - int'(pos_x)) >> SS;
      w   = rom_mem[a];
      e   = !w[15 - col];
    end
    cyc();
    check("rom_addr", 32'(rom_addr), (a < 0) ? 32'd0 : 32'(a));
    exp_q.push_back(e);
    if (exp_q.size() == 3) check("pix_on", 32'(pix_on), 32'(exp_q.pop_front()));
  endtask

  task automatic flush();
    present(0, 0);
    present(0, 0);
  endtask

  task automatic burst_random(int n);
    int rx;
    int ry;
    exp_q.delete();
    repeat (n) begin
      rx = $urandom_range(0, BOX + 16);
      ry = $urandom_range(0, BOX + 16);
      present(int'(pos_x) + rx - 8, int'(pos_y) + ry - 8);
    end
    flush();
  endtask

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 16'($urandom);
    rom_mem[0]  = 16'b1111110000111111;
    rom_mem[25] = 16'h0000;

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_pix_on", 32'(pix_on), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_act", 32'(act_cur), 32'd0);
    check("rst_frame", 32'(frame_cur), 32'd0);
    rst = 1'b0;
    cyc();

    // Directed pixels and box edges, pose stay/0
    m_sa = 0;
    m_sf = 0;
    exp_q.delete();
    present(100, 200);
    present(124, 200);
    present(99, 200);
    present(164, 200);
    present(100, 264);
    present(163, 263);
    present(163, 200);
    flush();
    burst_random(40);

    // Box partly off the right edge: no wrap
    pos_x = 10'd600;
    pos_y = 10'd10;
    burst_random(30);
    pos_x = 10'd100;
    pos_y = 10'd200;

    // Forward held: frame advance every FD ticks, wrap after 4*FD
    act_valid = 1'b1;
    act_req   = 3'd1;
    cyc();
    check("fwd_act", 32'(act_cur), 32'd1);
    check("fwd_busy", 32'(busy), 32'd0);
    fticks(FD - 1);
    check("fwd_frame_hold", 32'(frame_cur), 32'd0);
    ftick();
    check("fwd_frame_1", 32'(frame_cur), 32'd1);
    fticks(3 * FD - 1);
    check("fwd_frame_3", 32'(frame_cur), 32'd3);
    ftick();
    check("fwd_frame_wrap", 32'(frame_cur), 32'd0);
    act_valid = 1'b0;
    cyc();
    check("fwd_drop_act", 32'(act_cur), 32'd0);
    check("fwd_drop_frame", 32'(frame_cur), 32'd0);

    // Backward with a random number of irregularly spaced ticks
    act_valid = 1'b1;
    act_req   = 3'd2;
    cyc();
    check("bwd_act", 32'(act_cur), 32'd2);
    t = $urandom_range(1, 40);
    for (int k = 0; k < t; k++) begin
      repeat ($urandom_range(0, 3)) cyc();
      ftick();
    end
    check("bwd_frame", 32'(frame_cur), 32'((t / FD) % 4));
    m_sa = 2;
    m_sf = ((t - 1) / FD) % 4;
    burst_random(30);
    act_valid = 1'b0;
    cyc();
    check("bwd_drop_act", 32'(act_cur), 32'd0);

    // Punch, then kick held throughout: kick waits for punch to finish
    act_valid = 1'b1;
    act_req   = 3'd3;
    cyc();
    check("punch_busy", 32'(busy), 32'd1);
    check("punch_act", 32'(act_cur), 32'd3);
    act_req = 3'd4;
    cyc();
    check("kick_ignored", 32'(act_cur), 32'd3);
    fticks(4 * FD - 1);
    check("punch_last_busy", 32'(busy), 32'd1);
    check("punch_last_frame", 32'(frame_cur), 32'd3);
    ftick();
    check("punch_done_busy", 32'(busy), 32'd0);
    check("punch_done_act", 32'(act_cur), 32'd0);
    cyc();
    check("kick_taken", 32'(act_cur), 32'd4);
    check("kick_busy", 32'(busy), 32'd1);
    act_valid = 1'b0;
    fticks(4 * FD);
    check("kick_done", 32'(busy), 32'd0);

    // Punch request coincident with frame_tick
    fticks(3);
    pix_x = 10'd100;
    pix_y = 10'd200;
    act_valid  = 1'b1;
    act_req    = 3'd3;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    act_valid  = 1'b0;
    check("coin_act", 32'(act_cur), 32'd3);
    check("coin_frame", 32'(frame_cur), 32'd0);
    cyc();
    addr_snap = rom_addr;
    check("coin_shadow_old", 32'(addr_snap[5:3]), 32'd0);
    ftick();
    cyc();
    addr_snap = rom_addr;
    check("coin_shadow_new", 32'(addr_snap[5:3]), 32'd3);
    fticks(FD - 2);
    check("coin_div_cleared", 32'(frame_cur), 32'd0);
    ftick();
    check("coin_frame_1", 32'(frame_cur), 32'd1);
    fticks(3 * FD);
    check("coin_done", 32'(busy), 32'd0);

    // Invalid action code is ignored
    act_valid = 1'b1;
    act_req   = 3'd6;
    cyc();
    cyc();
    check("inv_act", 32'(act_cur), 32'd0);
    check("inv_busy", 32'(busy), 32'd0);
    act_valid = 1'b0;

    // Asynchronous reset in the middle of a punch
    act_valid = 1'b1;
    act_req   = 3'd3;
    cyc();
    act_valid = 1'b0;
    fticks(FD + 2);
    cyc();
    cyc();
    cyc();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_frame", 32'(frame_cur), 32'd1);
    check("mid_pix_lit", 32'(pix_on), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_act", 32'(act_cur), 32'd0);
    check("arst_pix_on", 32'(pix_on), 32'd0);
    check("arst_rom_addr", 32'(rom_addr), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    check("post_rst_pix_on", 32'(pix_on), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
